// File: rtl/cpld_link_pkg.sv
// Shared constants and types for the FPGA-to-CPLD serial peripheral link.
package cpld_link_pkg;

  localparam int FRAME_BITS = 16;

  localparam int LED_LSB = 0;
  localparam int SEG_LSB = 8;
  localparam int NAV_U   = 8;
  localparam int NAV_D   = 9;
  localparam int NAV_L   = 10;
  localparam int NAV_R   = 11;
  localparam int NAV_SEL = 12;

  localparam logic [4:0] RISE_SAT = 5'd17;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for one asynchronous line, plus a history flop
// so that rising and falling edges can be flagged in the clk domain.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      hist   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/cpld_responder.sv
// Slave end of the 16-bit CPLD link: receives LED/segment words on mosi and
// returns a button/switch snapshot on miso, framed by the master's load strobe.
module cpld_responder
  import cpld_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = cpld_link_pkg::FRAME_BITS
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cpld_clk,
  input  logic       cpld_mosi,
  input  logic       cpld_load,
  input  logic [4:0] nav_btn,
  input  logic [7:0] sw,
  output logic       cpld_miso,
  output logic [7:0] led,
  output logic [7:0] seg,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam logic [4:0] FULL_CNT = 5'(FRAME_BITS);

  logic sclk_q, sclk_rise, sclk_fall;
  logic load_q, load_rise, load_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rstn(rstn), .d(cpld_clk),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load (
    .clk(clk), .rstn(rstn), .d(cpld_load),
    .q(load_q), .rise(load_rise), .fall(load_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .rstn(rstn), .d(cpld_mosi),
    .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Only the synchronized level of mosi and the edges of sclk/load are used.
  logic unused_sync;
  assign unused_sync = ^{sclk_q, load_q, load_rise, mosi_rise, mosi_fall};

  logic [SYNC_STAGES-1:0][12:0] in_pipe;
  logic [4:0]                   nav_s;
  logic [7:0]                   sw_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) in_pipe <= '0;
    else       in_pipe <= {in_pipe[SYNC_STAGES-2:0], {nav_btn, sw}};
  end

  assign {nav_s, sw_s} = in_pipe[SYNC_STAGES-1];

  state_t state_q, state_d;
  logic   tx_active;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    tx_active = (state_q == RUN);
    if (load_fall) state_d = RUN;
  end

  logic [FRAME_BITS-1:0] rx_shift, rx_next;
  logic [FRAME_BITS-1:0] tx_word, tx_word_next;
  logic [4:0]            rise_cnt, cnt_next;
  logic [3:0]            bit_cnt;

  // A rise coinciding with load_fall is shifted and counted before the commit.
  always_comb begin
    rx_next      = rx_shift;
    cnt_next     = rise_cnt;
    tx_word_next = {{(FRAME_BITS-13){1'b0}}, nav_s, sw_s};
    if (sclk_rise) begin
      rx_next = {mosi_q, rx_shift[FRAME_BITS-1:1]};
      if (rise_cnt != RISE_SAT) cnt_next = rise_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_shift    <= '0;
      rise_cnt    <= '0;
      bit_cnt     <= '0;
      tx_word     <= '0;
      cpld_miso   <= 1'b0;
      led         <= '0;
      seg         <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_shift    <= rx_next;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (load_fall) begin
        rise_cnt  <= '0;
        tx_word   <= tx_word_next;
        bit_cnt   <= '0;
        cpld_miso <= tx_word_next[0];
        if (cnt_next == FULL_CNT) begin
          led         <= rx_next[LED_LSB +: 8];
          seg         <= rx_next[SEG_LSB +: 8];
          frame_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end else begin
        rise_cnt <= cnt_next;
        if (sclk_fall && tx_active) begin
          bit_cnt   <= bit_cnt + 4'd1;
          cpld_miso <= tx_word[bit_cnt + 4'd1];
        end
      end
    end
  end

endmodule
